// File: rtl/scene_pkg.sv
// Shared encodings for the demo scene sequencer: scene and layer codes,
// sprite start position, and the playlist step helper.
package scene_pkg;

  typedef enum logic [1:0] {
    SC_TEXT   = 2'd0,
    SC_SPRITE = 2'd1,
    SC_CUBE   = 2'd2,
    SC_ALL    = 2'd3
  } scene_t;

  typedef enum logic [1:0] {
    LY_NONE   = 2'd0,
    LY_TEXT   = 2'd1,
    LY_SPRITE = 2'd2,
    LY_VECTOR = 2'd3
  } layer_t;

  localparam logic [9:0] SPRITE_X0 = 10'd100;
  localparam logic [9:0] SPRITE_Y0 = 10'd150;

  // The playlist is a plain 4-entry ring, so the next scene is the code plus one.
  function automatic scene_t next_scene(input scene_t s);
    return scene_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Start-of-vertical-blanking detector: one registered pulse per frame, no matter
// how many clocks the beam position sits on the trigger point.
module frame_tick_gen #(
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic       frame_tick
);

  logic cond;
  logic cond_d;

  assign cond = (x_pos == 10'd0) && (y_pos == 10'(V_ACTIVE));

  // cond_d resets high so a blanking interval already in progress at reset
  // release is not mistaken for a fresh start of blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_d     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cond_d     <= cond;
      frame_tick <= cond & ~cond_d;
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Frame-synchronous playlist scheduler: scene FSM, sprite/cube animators and a
// registered three-layer pixel compositor.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int SCENE_FRAMES = 120,
  parameter int ROT_DIV      = 8,
  parameter int SPR_SIZE     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       display_on,
  input  logic       text_pixel,
  input  logic       sprite_pixel,
  input  logic       vector_pixel,
  input  logic       pause,
  input  logic       skip,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic [1:0] rotation,
  output logic [1:0] scene,
  output logic       frame_tick,
  output logic       pix_on,
  output logic [1:0] pix_layer
);

  localparam int CNT_W = $clog2(SCENE_FRAMES);
  localparam int DIV_W = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SPR_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - SPR_SIZE);

  scene_t             scene_q, scene_nxt;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic [DIV_W-1:0]   rot_div;
  logic               skip_d, skip_latch, skip_latch_nxt;
  logic               dx_pos, dy_pos;
  logic               step;
  logic               en_text, en_sprite, en_vector;
  layer_t             layer_c;

  frame_tick_gen #(.V_ACTIVE(V_ACTIVE)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .frame_tick (frame_tick)
  );

  assign step  = frame_tick & ~pause;
  assign scene = scene_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scene_q    <= SC_TEXT;
      frame_cnt  <= '0;
      skip_latch <= 1'b0;
      skip_d     <= 1'b0;
    end else begin
      scene_q    <= scene_nxt;
      frame_cnt  <= frame_cnt_nxt;
      skip_latch <= skip_latch_nxt;
      skip_d     <= skip;
    end
  end

  // A skip edge seen on a tick clock sets the latch after this tick has used
  // the old latch value, so it is honoured on the following tick.
  always_comb begin
    scene_nxt      = scene_q;
    frame_cnt_nxt  = frame_cnt;
    skip_latch_nxt = skip_latch;
    if (step) begin
      if (skip_latch) begin
        scene_nxt      = next_scene(scene_q);
        frame_cnt_nxt  = '0;
        skip_latch_nxt = 1'b0;
      end else if (frame_cnt == CNT_W'(SCENE_FRAMES - 1)) begin
        scene_nxt     = next_scene(scene_q);
        frame_cnt_nxt = '0;
      end else begin
        frame_cnt_nxt = frame_cnt + 1'b1;
      end
    end
    if (skip && !skip_d) skip_latch_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_div  <= '0;
      rotation <= 2'd0;
    end else if (step && (scene_q == SC_CUBE || scene_q == SC_ALL)) begin
      if (rot_div == DIV_W'(ROT_DIV - 1)) begin
        rot_div  <= '0;
        rotation <= rotation + 2'd1;
      end else begin
        rot_div <= rot_div + 1'b1;
      end
    end
  end

  // At a wall the direction flips and the position holds for that one tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_x <= SPRITE_X0;
      sprite_y <= SPRITE_Y0;
      dx_pos   <= 1'b1;
      dy_pos   <= 1'b1;
    end else if (step && (scene_q == SC_SPRITE || scene_q == SC_ALL)) begin
      if (dx_pos && sprite_x == X_MAX)        dx_pos   <= 1'b0;
      else if (!dx_pos && sprite_x == 10'd0)  dx_pos   <= 1'b1;
      else if (dx_pos)                        sprite_x <= sprite_x + 10'd1;
      else                                    sprite_x <= sprite_x - 10'd1;
      if (dy_pos && sprite_y == Y_MAX)        dy_pos   <= 1'b0;
      else if (!dy_pos && sprite_y == 10'd0)  dy_pos   <= 1'b1;
      else if (dy_pos)                        sprite_y <= sprite_y + 10'd1;
      else                                    sprite_y <= sprite_y - 10'd1;
    end
  end

  always_comb begin
    en_text   = (scene_q == SC_TEXT)   || (scene_q == SC_ALL);
    en_sprite = (scene_q == SC_SPRITE) || (scene_q == SC_ALL);
    en_vector = (scene_q == SC_CUBE)   || (scene_q == SC_ALL);
    layer_c   = LY_NONE;
    if (display_on) begin
      if (en_sprite && sprite_pixel)      layer_c = LY_SPRITE;
      else if (en_text && text_pixel)     layer_c = LY_TEXT;
      else if (en_vector && vector_pixel) layer_c = LY_VECTOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_layer <= 2'd0;
      pix_on    <= 1'b0;
    end else begin
      pix_layer <= layer_c;
      pix_on    <= (layer_c != LY_NONE);
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Scoreboard bench for scene_sequencer: a compressed-frame stimulus stub drives
// the beam position, a playlist model predicts per-tick state and per-clock pixels.
module tb_scene_sequencer;

  localparam int H_ACTIVE     = 120;
  localparam int V_ACTIVE     = 170;
  localparam int SCENE_FRAMES = 4;
  localparam int ROT_DIV      = 2;
  localparam int SPR_SIZE     = 16;
  localparam int X_MAX        = H_ACTIVE - SPR_SIZE;
  localparam int Y_MAX        = V_ACTIVE - SPR_SIZE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic       display_on = 1'b0;
  logic       text_pixel = 1'b0;
  logic       sprite_pixel = 1'b0;
  logic       vector_pixel = 1'b0;
  logic       pause = 1'b0;
  logic       skip = 1'b0;
  logic [9:0] sprite_x, sprite_y;
  logic [1:0] rotation, scene, pix_layer;
  logic       frame_tick, pix_on;

  scene_sequencer #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .SCENE_FRAMES(SCENE_FRAMES),
    .ROT_DIV(ROT_DIV), .SPR_SIZE(SPR_SIZE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos),
    .display_on(display_on), .text_pixel(text_pixel),
    .sprite_pixel(sprite_pixel), .vector_pixel(vector_pixel),
    .pause(pause), .skip(skip), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .rotation(rotation), .scene(scene), .frame_tick(frame_tick),
    .pix_on(pix_on), .pix_layer(pix_layer)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int due; int scene; int rot; int sx; int sy; } st_exp_t;
  typedef struct { int due; int layer; } px_exp_t;
  st_exp_t st_q[$];
  px_exp_t px_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Playlist model state
  int m_scene, m_cnt, m_div, m_rot, m_sx, m_sy, m_dx, m_dy;
  bit m_latch, m_cond_prev, m_skip_prev, m_tick_now;
  bit pause_lvl = 1'b0;
  bit skip_lvl  = 1'b0;
  bit rnd_ctrl  = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic model_reset();
    m_scene = 0; m_cnt = 0; m_div = 0; m_rot = 0;
    m_sx = 100; m_sy = 150; m_dx = 1; m_dy = 1;
    m_latch = 0; m_cond_prev = 1; m_skip_prev = 0; m_tick_now = 0;
  endtask

  function automatic int comp_layer(input int sc, input bit d, input bit t, input bit s, input bit v);
    if (!d) return 0;
    if (s && (sc == 1 || sc == 3)) return 2;
    if (t && (sc == 0 || sc == 3)) return 1;
    if (v && (sc == 2 || sc == 3)) return 3;
    return 0;
  endfunction

  function automatic void bounce(inout int p, inout int d, input int lim);
    if (d > 0 && p == lim)    d = -1;
    else if (d < 0 && p == 0) d = 1;
    else                      p = p + d;
  endfunction

  task automatic tick_update(input bit paused);
    if (paused) return;
    if (m_scene == 2 || m_scene == 3) begin
      m_div++;
      if (m_div == ROT_DIV) begin m_div = 0; m_rot = (m_rot + 1) % 4; end
    end
    if (m_scene == 1 || m_scene == 3) begin
      bounce(m_sx, m_dx, X_MAX);
      bounce(m_sy, m_dy, Y_MAX);
    end
    if (m_latch) begin
      m_scene = (m_scene + 1) % 4; m_cnt = 0; m_latch = 0;
    end else if (m_cnt == SCENE_FRAMES - 1) begin
      m_scene = (m_scene + 1) % 4; m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock of stimulus; expectations are queued with the cycle they are due.
  task automatic applyStimulus(input int x, input int y, input bit d, input bit t, input bit s, input bit v);
    px_exp_t pe;
    st_exp_t se;
    bit cond, skip_rise;
    @(posedge clk); #1;
    x_pos = 10'(x); y_pos = 10'(y);
    display_on = d; text_pixel = t; sprite_pixel = s; vector_pixel = v;
    pause = pause_lvl; skip = skip_lvl;
    pe.due = cyc + 1;
    pe.layer = comp_layer(m_scene, d, t, s, v);
    px_q.push_back(pe);
    skip_rise = skip_lvl && !m_skip_prev;
    m_skip_prev = skip_lvl;
    if (m_tick_now) tick_update(pause_lvl);
    if (skip_rise) m_latch = 1;
    cond = (x == 0) && (y == V_ACTIVE);
    m_tick_now = cond && !m_cond_prev;
    m_cond_prev = cond;
    if (m_tick_now) begin
      se.due = cyc + 1; se.scene = m_scene; se.rot = m_rot; se.sx = m_sx; se.sy = m_sy;
      st_q.push_back(se);
    end
  endtask

  task automatic do_frame(input int hold);
    int n;
    n = int'($urandom_range(3, 6));
    for (int i = 0; i < n; i++) begin
      if (rnd_ctrl && $urandom_range(0, 7) == 0) skip_lvl = ~skip_lvl;
      applyStimulus(int'($urandom_range(0, H_ACTIVE - 1)), int'($urandom_range(0, V_ACTIVE - 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < hold; i++) begin
      if (rnd_ctrl && $urandom_range(0, 5) == 0) skip_lvl = ~skip_lvl;
      applyStimulus(0, V_ACTIVE, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    applyStimulus(1, V_ACTIVE, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_scene", int'(scene), 0);
    checkOutput("rst_rotation", int'(rotation), 0);
    checkOutput("rst_sprite_x", int'(sprite_x), 100);
    checkOutput("rst_sprite_y", int'(sprite_y), 150);
    checkOutput("rst_frame_tick", int'(frame_tick), 0);
    checkOutput("rst_pix_on", int'(pix_on), 0);
    checkOutput("rst_pix_layer", int'(pix_layer), 0);
  endtask

  px_exp_t mon_pe;
  st_exp_t mon_se;

  always @(negedge clk) begin
    if (rst_n) begin
      if (px_q.size() > 0 && px_q[0].due == cyc) begin
        mon_pe = px_q.pop_front();
        checkOutput("pix_layer", int'(pix_layer), mon_pe.layer);
        checkOutput("pix_on", int'(pix_on), int'(mon_pe.layer != 0));
      end
      if (st_q.size() > 0 && st_q[0].due < cyc) begin
        checkOutput("tick_cycle", cyc, st_q[0].due);
        void'(st_q.pop_front());
      end
      if (frame_tick) begin
        if (st_q.size() > 0 && st_q[0].due == cyc) begin
          mon_se = st_q.pop_front();
          checkOutput("scene", int'(scene), mon_se.scene);
          checkOutput("rotation", int'(rotation), mon_se.rot);
          checkOutput("sprite_x", int'(sprite_x), mon_se.sx);
          checkOutput("sprite_y", int'(sprite_y), mon_se.sy);
        end else begin
          checkOutput("spurious_tick", int'(frame_tick), 0);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_values();
    @(posedge clk); #1 rst_n = 1'b1;

    // Plain playlist: scenes, rotation and first sprite bounce
    for (int f = 0; f < 26; f++) do_frame(int'($urandom_range(1, 3)));

    // Paused with a skip pulse inside; acted on at the first unpaused tick
    pause_lvl = 1'b1;
    for (int f = 0; f < 10; f++) begin
      if (f == 3) skip_lvl = 1'b1;
      if (f == 5) skip_lvl = 1'b0;
      do_frame(2);
    end
    pause_lvl = 1'b0;
    for (int f = 0; f < 3; f++) do_frame(1);

    // Compositor priority inside the ALL scene
    for (int f = 0; f < 20 && m_scene != 3; f++) do_frame(1);
    applyStimulus(5, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(10, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(10, 6, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(11, 6, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(12, 6, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised pause/skip traffic
    rnd_ctrl = 1'b1;
    for (int f = 0; f < 250; f++) begin
      pause_lvl = ($urandom_range(0, 3) == 0);
      do_frame(int'($urandom_range(1, 4)));
    end
    rnd_ctrl = 1'b0;
    pause_lvl = 1'b0;
    skip_lvl = 1'b0;
    for (int f = 0; f < 2; f++) do_frame(1);

    // Reset mid-line, then a long hold on the blanking trigger point
    applyStimulus(30, 40, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_reset_values();
    model_reset();
    px_q.delete();
    st_q.delete();
    x_pos = 10'd7; y_pos = 10'd7; display_on = 1'b0;
    text_pixel = 1'b0; sprite_pixel = 1'b0; vector_pixel = 1'b0;
    pause = 1'b0; skip = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_frame(6);
    for (int f = 0; f < 20; f++) do_frame(int'($urandom_range(1, 5)));

    repeat (3) @(posedge clk);
    #1 checkOutput("pending_ticks", st_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
